// File: rtl/instr_fetch_unit_if.sv
// Instruction fetch bus bundle.
// Groups the instruction-memory read handshake (IMEM_*), the instruction hand-off to the
// control unit (EXEC*), the branch redirect inputs and the halt status flag.
//   master : the fetch unit (drives IMEM_REQ/ADDR, EXEC, EXEC_VALID, EXEC_PC, HALTED)
//   slave  : memory / control unit / execute side (drives ACK, RDATA, READY, REDIRECT*)
interface instr_fetch_unit_if #(
   parameter int unsigned ADDR_W = 16
);
   logic              IMEM_REQ;
   logic [ADDR_W-1:0] IMEM_ADDR;
   logic              IMEM_ACK;
   logic [15:0]       IMEM_RDATA;
   logic [15:0]       EXEC;
   logic              EXEC_VALID;
   logic              EXEC_READY;
   logic [ADDR_W-1:0] EXEC_PC;
   logic              REDIRECT;
   logic [ADDR_W-1:0] REDIRECT_PC;
   logic              HALTED;

   modport master (
      output IMEM_REQ, IMEM_ADDR, EXEC, EXEC_VALID, EXEC_PC, HALTED,
      input  IMEM_ACK, IMEM_RDATA, EXEC_READY, REDIRECT, REDIRECT_PC
   );

   modport slave (
      input  IMEM_REQ, IMEM_ADDR, EXEC, EXEC_VALID, EXEC_PC, HALTED,
      output IMEM_ACK, IMEM_RDATA, EXEC_READY, REDIRECT, REDIRECT_PC
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit.
// Holds the fetch PC, issues one outstanding instruction-memory read at a time, buffers the
// returned word and presents it to the control unit with a valid/ready handshake. Branch
// redirects retarget fetch; a request already on the bus is never withdrawn, its data is
// dropped instead. All outputs are registered.
// Ports:
//   CLOCK : clock, rising edge
//   RESET : synchronous active-high reset
//   bus   : instr_fetch_unit_if.master (IMEM req/ack, EXEC valid/ready, REDIRECT, HALTED)
// Optional build macro HALT_DETECT_EN: stop fetching after an HLT word (bits [15:14]=2'b11,
// [7:4]=4'hF) has been consumed; only RESET leaves the halted state. Without it HALTED is 0.
module instr_fetch_unit #(
   parameter int unsigned       ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [15:0]       NOP_WORD = 16'h8800
) (
   input logic                CLOCK,
   input logic                RESET,
   instr_fetch_unit_if.master bus
);

   typedef enum logic [1:0] {StIdle, StFetch, StHold, StHalt} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] fpc_q, fpc_d;
   logic              discard_q, discard_d;
   logic              req_q, req_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       exec_q, exec_d;
   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] exec_pc_q, exec_pc_d;
`ifdef HALT_DETECT_EN
   logic              halted_q, halted_d;
`endif

   // Next fetch target: a redirect in this cycle overrides the stored PC.
   logic [ADDR_W-1:0] tgt;
   assign tgt = bus.REDIRECT ? bus.REDIRECT_PC : fpc_q;

   always_comb begin
      state_d   = state_q;
      fpc_d     = fpc_q;
      discard_d = discard_q;
      req_d     = req_q;
      addr_d    = addr_q;
      exec_d    = exec_q;
      valid_d   = valid_q;
      exec_pc_d = exec_pc_q;
`ifdef HALT_DETECT_EN
      halted_d  = halted_q;
`endif
      case (state_q)
         StIdle: begin
            fpc_d   = tgt;
            addr_d  = tgt;
            req_d   = 1'b1;
            state_d = StFetch;
         end
         StFetch: begin
            if (bus.IMEM_ACK) begin
               if (discard_q || bus.REDIRECT) begin
                  // Stale or redirected data: drop it and restart at the current target.
                  discard_d = 1'b0;
                  fpc_d     = tgt;
                  addr_d    = tgt;
               end else begin
                  exec_d    = bus.IMEM_RDATA;
                  valid_d   = 1'b1;
                  exec_pc_d = addr_q;
                  fpc_d     = addr_q + ADDR_W'(1);
                  req_d     = 1'b0;
                  state_d   = StHold;
               end
            end else if (bus.REDIRECT) begin
               // Request stays on the bus; remember to discard its data.
               fpc_d     = bus.REDIRECT_PC;
               discard_d = 1'b1;
            end
         end
         StHold: begin
            if (bus.REDIRECT) begin
               valid_d = 1'b0;
               exec_d  = NOP_WORD;
               fpc_d   = bus.REDIRECT_PC;
               addr_d  = bus.REDIRECT_PC;
               req_d   = 1'b1;
               state_d = StFetch;
            end else if (bus.EXEC_READY) begin
               valid_d = 1'b0;
               exec_d  = NOP_WORD;
`ifdef HALT_DETECT_EN
               if ((exec_q[15:14] == 2'b11) && (exec_q[7:4] == 4'hF)) begin
                  halted_d = 1'b1;
                  state_d  = StHalt;
               end else begin
                  addr_d  = fpc_q;
                  req_d   = 1'b1;
                  state_d = StFetch;
               end
`else
               addr_d  = fpc_q;
               req_d   = 1'b1;
               state_d = StFetch;
`endif
            end
         end
         StHalt: begin
            // Terminal until RESET; redirects are ignored.
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q   <= StIdle;
         fpc_q     <= RESET_PC;
         discard_q <= 1'b0;
         req_q     <= 1'b0;
         addr_q    <= RESET_PC;
         exec_q    <= NOP_WORD;
         valid_q   <= 1'b0;
         exec_pc_q <= '0;
`ifdef HALT_DETECT_EN
         halted_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         fpc_q     <= fpc_d;
         discard_q <= discard_d;
         req_q     <= req_d;
         addr_q    <= addr_d;
         exec_q    <= exec_d;
         valid_q   <= valid_d;
         exec_pc_q <= exec_pc_d;
`ifdef HALT_DETECT_EN
         halted_q  <= halted_d;
`endif
      end
   end

   assign bus.IMEM_REQ   = req_q;
   assign bus.IMEM_ADDR  = addr_q;
   assign bus.EXEC       = exec_q;
   assign bus.EXEC_VALID = valid_q;
   assign bus.EXEC_PC    = exec_pc_q;
`ifdef HALT_DETECT_EN
   assign bus.HALTED     = halted_q;
`else
   assign bus.HALTED     = 1'b0;
`endif

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the control unit; sole source of the 16-bit EXEC word the control unit decodes.
- Holds the program counter, issues single-outstanding read requests to instruction memory over a req/ack handshake, and buffers one fetched instruction.
- Presents the buffered instruction to the control unit with a valid/ready handshake and accepts branch redirects from the execute side.

Parameters:
- ADDR_W, 16, instruction address width; the PC wraps modulo 2^ADDR_W.
- RESET_PC, 0, first fetch address after reset.
- NOP_WORD, 16'h8800, bubble word driven on EXEC when no instruction is valid (op 10, sub 001: no control action).

Ports:
- CLOCK  in  1  clock; all state changes on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- IMEM_REQ  out  1  read request; level-held until acknowledged.
- IMEM_ADDR  out  ADDR_W  read address; stable while IMEM_REQ is high.
- IMEM_ACK  in  1  read completes in any cycle where IMEM_REQ && IMEM_ACK.
- IMEM_RDATA  in  16  instruction word; valid only in the completing cycle.
- EXEC  out  16  instruction to the control unit; equals NOP_WORD when EXEC_VALID=0.
- EXEC_VALID  out  1  EXEC holds a real instruction.
- EXEC_READY  in  1  consumer accepts EXEC this cycle.
- EXEC_PC  out  ADDR_W  address of the instruction currently on EXEC.
- REDIRECT  in  1  branch taken; refetch from REDIRECT_PC.
- REDIRECT_PC  in  ADDR_W  branch target.
- HALTED  out  1  fetch stopped on HLT; tied 0 without HALT_DETECT_EN.

Behaviour:
- All outputs are registered.
- Reset values: IMEM_REQ=0; IMEM_ADDR=RESET_PC; EXEC=NOP_WORD; EXEC_VALID=0; EXEC_PC=0; HALTED=0. Internal fpc=RESET_PC, discard=0, state=IDLE.
- IDLE: next cycle -> FETCH with IMEM_REQ=1 and IMEM_ADDR=fpc. First request is visible one cycle after RESET deasserts.
- FETCH, on ACK with discard=0 and no REDIRECT:
  - EXEC<=IMEM_RDATA; EXEC_VALID<=1; EXEC_PC<=IMEM_ADDR.
  - fpc<=IMEM_ADDR+1, truncated to ADDR_W (wraps).
  - IMEM_REQ<=0; -> HOLD.
- FETCH, REDIRECT without ACK: fpc<=REDIRECT_PC; discard<=1. IMEM_REQ and IMEM_ADDR are held until the ACK arrives.
- FETCH, ACK with discard=1 or with REDIRECT in the same cycle:
  - Data is dropped; discard<=0.
  - If REDIRECT is present, the new target is used.
  - Stay in FETCH; IMEM_ADDR<=fpc (new target); IMEM_REQ stays 1, starting a new transaction next cycle.
- HOLD: EXEC and EXEC_PC are stable and no request is issued.
  - On EXEC_READY: EXEC_VALID<=0; EXEC<=NOP_WORD; -> FETCH with IMEM_ADDR=fpc.
- HOLD with REDIRECT (with or without EXEC_READY): held instruction is retired/dropped; EXEC_VALID<=0; fpc<=REDIRECT_PC; -> FETCH at REDIRECT_PC.
- IDLE with REDIRECT: fetch starts at REDIRECT_PC instead of fpc.
- Throughput: with zero-wait ACK (ACK in the first REQ cycle) and READY held high, one instruction every 2 cycles.
- Latency: READY to next EXEC_VALID is 2 cycles minimum.
- Never more than one outstanding memory request. A REDIRECT never withdraws a pending request.
- RESET mid-transaction aborts immediately. A late ACK that arrives while IMEM_REQ=0 is ignored.

Optional Feature:
- Macro: HALT_DETECT_EN.
- Defined:
  - A captured word with [15:14]=2'b11 and [7:4]=4'b1111 (HLT) is presented on EXEC normally.
  - After it is consumed, the unit enters HALTED state: IMEM_REQ=0, EXEC_VALID=0, HALTED=1.
  - REDIRECT is ignored while halted; only RESET exits.
  - A REDIRECT while HLT is held in HOLD drops it and no halt occurs.
- Undefined: HLT is an ordinary word and fetch continues; HALTED is tied 0.

Test Plan:
- Zero-wait memory returning 16'hC010, 16'hC120, 16'h8005, 16'hC230 at addresses 0..3, READY=1 -> first IMEM_REQ one cycle after reset; EXEC shows the four words in order, each valid exactly one cycle, 2 cycles apart; EXEC_PC = 0,1,2,3.
- ACK delayed 3 cycles, READY low for 5 cycles after capture -> IMEM_ADDR stable during the wait; EXEC/EXEC_PC stable and no new IMEM_REQ while READY=0; next REQ 1 cycle after READY.
- REDIRECT to 16'h0040 while the request for 16'h0005 is pending -> ACK data for 5 dropped (EXEC_VALID stays 0); next request address 16'h0040; EXEC_PC=16'h0040.
- REDIRECT to 16'h0020 in the same cycle as ACK for 16'h0007 -> word dropped; IMEM_REQ stays high with address 16'h0020 next cycle.
- RESET_PC=16'hFFFF -> first fetch at 16'hFFFF, second at 16'h0000; RESET asserted during a pending request -> IMEM_REQ=0 and all outputs at reset values the next cycle.
- HALT_DETECT_EN defined, 16'hC0F0 at address 2 -> word presented; after READY, HALTED=1 and IMEM_REQ stays 0; REDIRECT ignored; RESET clears HALTED. Undefined: address 3 is fetched.
